flash_arbiter: RTL
==================

Name: flash_arbiter

Overview:
- Shares the single flash_interface control port between NREQ requesters (e.g. configuration loader, host register bridge).
- Captures each requester's single-cycle read/write strobe with its address and data, grants round-robin, and drives the one-pulse request/busy handshake toward flash_interface.
- Returns read data, a done pulse and an error flag to the granted requester; a timeout guards against a hung flash_interface.

Parameters:
NREQ, 2, number of requesters (2..8)
OP_TIMEOUT, 65535, max cycles spent in WAIT_ACK or WAIT_DONE before aborting with error (150 MHz clk)

Ports:
clk  in  1  system clock, 150 MHz
reset  in  1  asynchronous, active-low reset
req_rd  in  NREQ  per-requester read strobe, one-cycle pulse
req_wr  in  NREQ  per-requester write strobe, one-cycle pulse
req_addr  in  NREQ*26  per-requester address; slice i = [26*i+25:26*i]
req_wdata  in  NREQ*32  per-requester write data; slice i = [32*i+31:32*i]
req_busy  out  NREQ  requester i has a pending or in-service operation
req_done  out  NREQ  one-cycle completion pulse to requester i
req_err  out  1  valid with req_done: 1 = timeout abort
req_rdata  out  32  read data, valid in the req_done cycle
flash_read_req  out  1  to flash_interface read_req
flash_write_req  out  1  to flash_interface write_req
flash_addr  out  26  to flash_interface addr
flash_data_write  out  32  to flash_interface data_write
flash_data_read  in  32  from flash_interface data_read
flash_busy  in  1  from flash_interface busy

Behaviour:
- Reset (reset=0, async): all outputs 0, pending flags 0, state IDLE, rr pointer last=NREQ-1 (requester 0 wins first), timer 0.
- Capture: on req_rd[i] or req_wr[i] with pending[i]=0, set pending[i]; latch addr slice, wdata slice and op (wr=1 if req_wr[i]). Both strobes in the same cycle: write wins. Strobe while pending[i]=1 or in service: ignored, no error.
- req_busy[i] = pending[i] OR (state != IDLE AND grant == i); goes high the cycle after the accepted strobe.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, COMPLETE.
- IDLE: if any pending AND flash_busy=0, choose the first pending index searching from last+1 modulo NREQ. Set grant, last=grant, clear pending[grant], load flash_addr/flash_data_write from the latches, go to ISSUE. If flash_busy=1 (e.g. after reset), stay in IDLE.
- ISSUE: drive flash_read_req or flash_write_req high for exactly this one cycle; clear timer; go to WAIT_ACK.
- WAIT_ACK: flash_busy=1 -> WAIT_DONE with timer cleared. Timer reaches OP_TIMEOUT -> COMPLETE with err=1.
- WAIT_DONE: flash_busy=0 -> register flash_data_read into req_rdata, go to COMPLETE, err=0. Timer reaches OP_TIMEOUT -> COMPLETE with err=1, req_rdata=0.
- COMPLETE: req_done[grant]=1 and req_err=err for one cycle; -> IDLE.
- req_rdata holds its value until the next completion. For writes, req_rdata is still loaded from flash_data_read, and requesters ignore it.
- Minimum service latency: strobe at cycle t, ISSUE at t+2, done no earlier than t+5 (flash busy for one cycle).
- A new strobe from requester i arriving during its own COMPLETE cycle is accepted, because pending[i] is already 0.
- Timer width: clog2(OP_TIMEOUT+1); it saturates and never wraps.
- flash_addr and flash_data_write stay stable from ISSUE through COMPLETE.
- flash_*_req are never high outside ISSUE; at most one of them is high.

Test Plan:
- Single read: req_rd[0] with addr 0x0000100; model flash_busy high 4 cycles with data 0xDEADBEEF -> one flash_read_req pulse, flash_addr=0x0000100, req_done[0] pulse, req_rdata=0xDEADBEEF, req_err=0.
- Round robin: req_wr[0] and req_wr[1] in the same cycle, then both again after completion -> service order 1? no: 0,1 on the first pair, then 0,1 again; flash_data_write matches each requester's latched wdata (0x11111111, 0x22222222).
- Contention/ignore: req_rd[1] pulsed 3 times while its first op is in service -> exactly one flash_read_req for requester 1; req_busy[1] high throughout.
- Timeout: flash_busy never rises, OP_TIMEOUT=16 -> req_done pulse with req_err=1 at ISSUE+17 cycles; the next pending op is then serviced normally.
- Busy at start: flash_busy=1 out of reset with req_rd[0] pending -> no flash_read_req until flash_busy drops, then issue within 2 cycles.
- Reset mid-operation: reset asserted in WAIT_DONE -> all outputs 0 immediately (asynchronous), pending cleared; after release, requester 0 has priority.

Source files
------------

// File: rtl/flash_arbiter.sv
// rtl/flash_arbiter.sv - round-robin arbiter sharing one flash_interface control port
module flash_arbiter #(
    parameter int NREQ       = 2,
    parameter int OP_TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_rd,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [NREQ*26-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    req_busy,
    output logic [NREQ-1:0]    req_done,
    output logic               req_err,
    output logic [31:0]        req_rdata,
    output logic               flash_read_req,
    output logic               flash_write_req,
    output logic [25:0]        flash_addr,
    output logic [31:0]        flash_data_write,
    input  logic [31:0]        flash_data_read,
    input  logic               flash_busy
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(OP_TIMEOUT + 1);
    localparam logic [IW:0]   NREQ_W = (IW+1)'(NREQ);
    localparam logic [TW-1:0] TMO    = TW'(OP_TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, COMPLETE} state_t;
    state_t state, state_nxt;

    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] lat_wr;
    logic [25:0]     lat_addr  [NREQ];
    logic [31:0]     lat_wdata [NREQ];
    logic [IW-1:0]   grant, last, sel_idx;
    logic [IW:0]     sel_sum;
    logic            sel_valid;
    logic [TW-1:0]   timer, timer_inc;
    logic            timer_hit;
    logic            op_wr, err;
    logic [NREQ-1:0] grant_oh, in_service, accept;
    logic            start;

    always_comb begin
        grant_oh        = '0;
        grant_oh[grant] = 1'b1;
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        sel_sum   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sel_sum = {1'b0, last} + (IW+1)'(k);
            if (sel_sum >= NREQ_W)
                sel_sum = sel_sum - NREQ_W;
            if (!sel_valid && pending[sel_sum[IW-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = sel_sum[IW-1:0];
            end
        end
    end

    assign start      = (state == IDLE) && sel_valid && !flash_busy;
    assign timer_inc  = (timer == TMO) ? timer : timer + TW'(1);
    assign timer_hit  = (timer_inc == TMO);
    // COMPLETE is deliberately not "in service" so a fresh strobe there is taken
    assign in_service = (state == ISSUE || state == WAIT_ACK || state == WAIT_DONE) ? grant_oh : '0;
    assign accept     = (req_rd | req_wr) & ~pending & ~in_service;

    assign req_busy        = pending | ((state != IDLE) ? grant_oh : '0);
    assign req_done        = (state == COMPLETE) ? grant_oh : '0;
    assign req_err         = (state == COMPLETE) && err;
    assign flash_read_req  = (state == ISSUE) && !op_wr;
    assign flash_write_req = (state == ISSUE) && op_wr;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_ACK;
            WAIT_ACK:  if (flash_busy) state_nxt = WAIT_DONE;
                       else if (timer_hit) state_nxt = COMPLETE;
            WAIT_DONE: if (!flash_busy || timer_hit) state_nxt = COMPLETE;
            COMPLETE:  state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending          <= '0;
            lat_wr           <= '0;
            grant            <= '0;
            last             <= IW'(NREQ - 1);
            timer            <= '0;
            op_wr            <= 1'b0;
            err              <= 1'b0;
            req_rdata        <= '0;
            flash_addr       <= '0;
            flash_data_write <= '0;
            for (int i = 0; i < NREQ; i++) begin
                lat_addr[i]  <= '0;
                lat_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i]) begin
                    pending[i]   <= 1'b1;
                    lat_wr[i]    <= req_wr[i];
                    lat_addr[i]  <= req_addr[26*i +: 26];
                    lat_wdata[i] <= req_wdata[32*i +: 32];
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        grant            <= sel_idx;
                        last             <= sel_idx;
                        pending[sel_idx] <= 1'b0;
                        op_wr            <= lat_wr[sel_idx];
                        flash_addr       <= lat_addr[sel_idx];
                        flash_data_write <= lat_wdata[sel_idx];
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    err   <= 1'b0;
                end
                WAIT_ACK: begin
                    if (flash_busy) begin
                        timer <= '0;
                    end else if (timer_hit) begin
                        err       <= 1'b1;
                        req_rdata <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!flash_busy) begin
                        req_rdata <= flash_data_read;
                        err       <= 1'b0;
                    end else if (timer_hit) begin
                        err       <= 1'b1;
                        req_rdata <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
